operand_driver: RTL and testbench

//  Stimulus/capture end of the two-operand datapath interface: generates the data_a/data_b operand

---
 rtl/operand_driver_pkg.sv | 22 ++
 rtl/operand_driver_if.sv | 30 +++
 rtl/operand_driver_sync_fifo.sv | 72 +++++++
 rtl/operand_driver.sv | 106 ++++++++++
 tb/tb_operand_driver.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_driver_pkg.sv
// Shared types and width helpers for the operand driver and its capture FIFO.
package operand_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int IDX_W = 8;
    localparam int LAT_W = 3;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/operand_driver_if.sv
// Operand stream, result capture and read-port signals between the driver and its environment.
interface operand_driver_if #(
    parameter int DATA_W    = 8,
    parameter int CAP_DEPTH = 8
);
    import operand_driver_pkg::*;

    logic                          start;
    logic [DATA_W-1:0]             data_a;
    logic [DATA_W-1:0]             data_b;
    logic [DATA_W-1:0]             dut_out;
    logic                          busy;
    logic                          done;
    logic                          rd_en;
    logic [DATA_W-1:0]             rd_data;
    logic                          rd_valid;
    logic [cnt_w(CAP_DEPTH)-1:0]   cap_count;
    logic                          overflow;

    modport master (
        input  start, dut_out, rd_en,
        output data_a, data_b, busy, done, rd_data, rd_valid, cap_count, overflow
    );

    modport slave (
        output start, dut_out, rd_en,
        input  data_a, data_b, busy, done, rd_data, rd_valid, cap_count, overflow
    );

endinterface

// File: rtl/operand_driver_sync_fifo.sv
// Capture FIFO: registered read port, sticky overflow, push accepted on full when a pop frees a slot.
module operand_driver_sync_fifo
    import operand_driver_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CAP_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           pop_data,
    output logic                        pop_valid,
    output logic [cnt_w(CAP_DEPTH)-1:0] count,
    output logic                        overflow
);
    localparam int PTR_W = ptr_w(CAP_DEPTH);
    localparam int CNT_W = cnt_w(CAP_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CAP_DEPTH);

    logic [DATA_W-1:0] mem [CAP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              empty;
    logic              pop_ok;
    logic              push_ok;

    always_comb begin
        full    = (count == DEPTH_C);
        empty   = (count == '0);
        pop_ok  = pop && !empty;
        // On full, the slot freed by a same-cycle pop is reused by the push.
        push_ok = push && (!full || pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
            if (pop_ok) begin
                pop_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_driver.sv
// Cycle-exact operand sequencer for the two-operand datapath, with latency-aligned result capture.
module operand_driver
    import operand_driver_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int A_START   = 0,
    parameter int A_STEP    = 40,
    parameter int B_START   = 177,
    parameter int B_STEP    = 16,
    parameter int N_VEC     = 5,
    parameter int LATENCY   = 1,
    parameter int CAP_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    operand_driver_if.master     io
);
    localparam logic [DATA_W-1:0] A_INIT   = DATA_W'(A_START);
    localparam logic [DATA_W-1:0] A_INC    = DATA_W'(A_STEP);
    localparam logic [DATA_W-1:0] B_INIT   = DATA_W'(B_START);
    localparam logic [DATA_W-1:0] B_DEC    = DATA_W'(B_STEP);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_VEC - 1);
    localparam logic [LAT_W-1:0]  LAST_LAT = LAT_W'(LATENCY - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [LAT_W-1:0]   lat_cnt;
    logic [LATENCY-1:0] pipe;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic               busy_q;
    logic               done_q;
    logic               in_drive;

    always_comb begin
        in_drive  = (state == ST_DRIVE);
        io.data_a = a_q;
        io.data_b = b_q;
        io.busy   = busy_q;
        io.done   = done_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            lat_cnt <= '0;
            pipe    <= '0;
            a_q     <= A_INIT;
            b_q     <= B_INIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Valid marker for each presented vector; its tail lines up with the result on dut_out.
            pipe <= LATENCY'({pipe, in_drive});
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (io.start) begin
                        state  <= ST_DRIVE;
                        idx    <= '0;
                        a_q    <= A_INIT;
                        b_q    <= B_INIT;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (idx == LAST_IDX) begin
                        state   <= ST_DRAIN;
                        lat_cnt <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                        a_q <= a_q + A_INC;
                        b_q <= b_q - B_DEC;
                    end
                end
                ST_DRAIN: begin
                    if (lat_cnt == LAST_LAT) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    operand_driver_sync_fifo #(
        .DATA_W    (DATA_W),
        .CAP_DEPTH (CAP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe[LATENCY-1]),
        .push_data (io.dut_out),
        .pop       (io.rd_en),
        .pop_data  (io.rd_data),
        .pop_valid (io.rd_valid),
        .count     (io.cap_count),
        .overflow  (io.overflow)
    );

endmodule

// File: tb/tb_operand_driver.sv
// Self-checking bench for operand_driver: spec vector tables, directed corner sequences, random run vs model.
module tb_operand_driver;

    localparam int NV    = 5;
    localparam int LAT   = 1;
    localparam int DEPTH = 8;
    localparam int A0    = 0;
    localparam int AS    = 40;
    localparam int B0    = 177;
    localparam int BS    = 16;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    operand_driver_if #(.DATA_W(8), .CAP_DEPTH(DEPTH)) ifa ();
    operand_driver_if #(.DATA_W(8), .CAP_DEPTH(DEPTH)) ifb ();

    operand_driver #(.DATA_W(8), .N_VEC(NV), .LATENCY(LAT), .CAP_DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .io    (ifa.master)
    );

    operand_driver #(.DATA_W(8), .N_VEC(10), .LATENCY(LAT), .CAP_DEPTH(DEPTH)) u_dut10 (
        .clk   (clk),
        .reset (reset),
        .io    (ifb.master)
    );

    // Registered adder standing in for the arithmetic block (one cycle of latency).
    always @(posedge clk) begin
        ifa.dut_out <= ifa.data_a + ifa.data_b;
        ifb.dut_out <= ifb.data_a + ifb.data_b;
    end

    int n_pass = 0;
    int n_total = 0;

    // Reference model for u_dut: run phase counter plus a result queue.
    int         m_ph = -1;
    logic [7:0] m_q[$];
    logic [7:0] m_rd_data = 8'd0;
    logic       m_rd_valid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_pop;
    logic       m_push;
    logic [7:0] m_cap;

    vec_t       tab[NV];
    logic [7:0] exp4[8];

    function automatic logic [7:0] op_a(input int i);
        return 8'(A0 + i * AS);
    endfunction

    function automatic logic [7:0] op_b(input int i);
        return 8'(B0 - i * BS);
    endfunction

    function automatic logic [7:0] op_sum(input int i);
        return 8'(A0 + i * AS + B0 - i * BS);
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_ph       = -1;
            m_q.delete();
            m_rd_data  = 8'd0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            m_pop  = ifa.rd_en && (m_q.size() > 0);
            m_push = (m_ph >= LAT) && (m_ph < NV + LAT);
            m_cap  = op_sum(m_ph - LAT);
            m_rd_valid = m_pop;
            if (m_pop) m_rd_data = m_q.pop_front();
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_cap);
                else m_ovf = 1'b1;
            end
            if (ifa.start && (m_ph < 0 || m_ph >= NV + LAT)) m_ph = 0;
            else if (m_ph >= 0 && m_ph < NV + LAT) m_ph = m_ph + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_all(input string tag);
        int idx;
        idx = (m_ph < 0) ? 0 : ((m_ph < NV) ? m_ph : NV - 1);
        chk({tag, "_data_a"},    32'(ifa.data_a),    32'(op_a(idx)));
        chk({tag, "_data_b"},    32'(ifa.data_b),    32'(op_b(idx)));
        chk({tag, "_busy"},      32'(ifa.busy),      32'(m_ph >= 0 && m_ph < NV + LAT));
        chk({tag, "_done"},      32'(ifa.done),      32'(m_ph >= NV + LAT));
        chk({tag, "_rd_valid"},  32'(ifa.rd_valid),  32'(m_rd_valid));
        chk({tag, "_rd_data"},   32'(ifa.rd_data),   32'(m_rd_data));
        chk({tag, "_cap_count"}, 32'(ifa.cap_count), 32'(m_q.size()));
        chk({tag, "_overflow"},  32'(ifa.overflow),  32'(m_ovf));
    endtask

    initial begin
        tab[0] = '{8'd0,   8'd177, 8'd177};
        tab[1] = '{8'd40,  8'd161, 8'd201};
        tab[2] = '{8'd80,  8'd145, 8'd225};
        tab[3] = '{8'd120, 8'd129, 8'd249};
        tab[4] = '{8'd160, 8'd113, 8'd17};
        exp4 = '{8'd225, 8'd249, 8'd17, 8'd177, 8'd201, 8'd225, 8'd249, 8'd17};

        ifa.start = 1'b0; ifa.rd_en = 1'b0;
        ifb.start = 1'b0; ifb.rd_en = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        chk("rst_data_a", 32'(ifa.data_a), 32'd0);
        chk("rst_data_b", 32'(ifa.data_b), 32'd177);
        chk("rst_rd_data", 32'(ifa.rd_data), 32'd0);
        check_all("rst");
        reset = 1'b1;
        tick();

        // Single run: five consecutive vectors, DRAIN, then DONE.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int i = 0; i < NV; i++) begin
            chk("t1_vec_a", 32'(ifa.data_a), 32'(tab[i].a));
            chk("t1_vec_b", 32'(ifa.data_b), 32'(tab[i].b));
            chk("t1_busy", 32'(ifa.busy), 32'd1);
            check_all("t1");
            tick();
        end
        chk("t1_drain_busy", 32'(ifa.busy), 32'd1);
        chk("t1_drain_done", 32'(ifa.done), 32'd0);
        tick();
        chk("t1_done", 32'(ifa.done), 32'd1);
        chk("t1_done_busy", 32'(ifa.busy), 32'd0);
        chk("t1_hold_a", 32'(ifa.data_a), 32'd160);
        check_all("t1_done");

        // Captured results, including the wrapped 17.
        chk("t2_count5", 32'(ifa.cap_count), 32'd5);
        ifa.rd_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            tick();
            chk("t2_rd_valid", 32'(ifa.rd_valid), 32'd1);
            chk("t2_rd_data", 32'(ifa.rd_data), 32'(tab[i].sum));
            check_all("t2");
        end
        ifa.rd_en = 1'b0;
        chk("t2_count0", 32'(ifa.cap_count), 32'd0);

        // Pop on empty is ignored and rd_data holds.
        ifa.rd_en = 1'b1;
        tick();
        ifa.rd_en = 1'b0;
        chk("t6_empty_valid", 32'(ifa.rd_valid), 32'd0);
        chk("t6_empty_hold", 32'(ifa.rd_data), 32'd17);
        check_all("t6_empty");

        // Rerun from DONE with a start pulse during DRIVE that must be ignored.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int i = 0; i < NV; i++) begin
            chk("t6_vec_a", 32'(ifa.data_a), 32'(tab[i].a));
            chk("t6_vec_b", 32'(ifa.data_b), 32'(tab[i].b));
            check_all("t6");
            ifa.start = (i == 1);
            tick();
        end
        ifa.start = 1'b0;
        check_all("t6_drain");
        tick();
        chk("t6_done", 32'(ifa.done), 32'd1);
        check_all("t6_done");
        ifa.rd_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            tick();
            chk("t6_rd_data", 32'(ifa.rd_data), 32'(tab[i].sum));
            check_all("t6_pop");
        end
        ifa.rd_en = 1'b0;

        // Fill to 8, then pop during the last two captures: count stays 8, no overflow.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (7) begin
            tick();
            check_all("t4_run1");
        end
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int k = 0; k < 20 && m_q.size() != DEPTH; k++) tick();
        chk("t4_full", 32'(ifa.cap_count), 32'd8);
        ifa.rd_en = 1'b1;
        tick();
        chk("t4_cnt_a", 32'(ifa.cap_count), 32'd8);
        chk("t4_ovf_a", 32'(ifa.overflow), 32'd0);
        chk("t4_rd_a", 32'(ifa.rd_data), 32'd177);
        check_all("t4_a");
        tick();
        ifa.rd_en = 1'b0;
        chk("t4_cnt_b", 32'(ifa.cap_count), 32'd8);
        chk("t4_ovf_b", 32'(ifa.overflow), 32'd0);
        chk("t4_rd_b", 32'(ifa.rd_data), 32'd201);
        check_all("t4_b");
        tick();
        ifa.rd_en = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("t4_order", 32'(ifa.rd_data), 32'(exp4[j]));
            check_all("t4_drain");
        end
        ifa.rd_en = 1'b0;

        // Reset asserted while vector 2 is on the bus.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick();
        tick();
        chk("t5_at_i2", 32'(ifa.data_a), 32'd80);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t5_data_a", 32'(ifa.data_a), 32'd0);
        chk("t5_data_b", 32'(ifa.data_b), 32'd177);
        chk("t5_count", 32'(ifa.cap_count), 32'd0);
        chk("t5_busy", 32'(ifa.busy), 32'd0);
        check_all("t5");

        // Random start/pop/reset traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 99) != 0);
            ifa.start = ($urandom_range(0, 11) == 0);
            ifa.rd_en = ($urandom_range(0, 2) == 0);
            tick();
            check_all("rnd");
        end
        reset = 1'b1;
        ifa.start = 1'b0;
        ifa.rd_en = 1'b0;
        tick();

        // Ten-vector run into an eight-deep FIFO without pops.
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        for (int k = 0; k < 40 && ifb.done !== 1'b1; k++) tick();
        chk("t3_done", 32'(ifb.done), 32'd1);
        chk("t3_count", 32'(ifb.cap_count), 32'd8);
        chk("t3_overflow", 32'(ifb.overflow), 32'd1);
        ifb.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_rd_valid", 32'(ifb.rd_valid), 32'd1);
            chk("t3_rd_data", 32'(ifb.rd_data), 32'(op_sum(i)));
        end
        ifb.rd_en = 1'b0;
        chk("t3_count0", 32'(ifb.cap_count), 32'd0);
        chk("t3_ovf_sticky", 32'(ifb.overflow), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
